// File: rtl/alu_unit_pkg.sv
// ---------------------------------------------------------------------------
// alu_unit_pkg
//   Shared ALU op-code definitions. The control unit imports this same
//   package so the op encoding lives in exactly one place.
//   Codes 6 and 7 are reserved and behave like NOP (done still pulses).
// ---------------------------------------------------------------------------
package alu_unit_pkg;

    typedef enum logic [2:0] {
        ALU_NOP  = 3'd0,
        ALU_ADD  = 3'd1,
        ALU_MUL  = 3'd2,
        ALU_SUB  = 3'd3,
        ALU_SFTR = 3'd4,
        ALU_SFTL = 3'd5
    } alu_op_e;

endpackage

// File: rtl/alu_unit_seq_multiplier.sv
// ---------------------------------------------------------------------------
// seq_multiplier
//   Iterative shift-add multiplier, one partial product per clock, fixed
//   latency of DATA_W iterations (no early exit).
//
// Ports
//   clk      in   system clock
//   rst_n    in   synchronous active-low reset; aborts any multiply
//   start    in   load a/b and begin iterating (ignored while busy)
//   a, b     in   multiplicand / multiplier, sampled on the start edge
//   busy     out  high while iterating
//   done     out  high during the cycle whose rising edge performs the
//                 final iteration; the parent commits product on that edge
//   product  out  low DATA_W bits of a*b, valid while done is high
// ---------------------------------------------------------------------------
module seq_multiplier #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] product
);

    logic [DATA_W-1:0] mcand_reg;
    logic [DATA_W-1:0] mplier_reg;
    logic [DATA_W-1:0] acc_reg;
    logic [DATA_W-1:0] acc_next;
    logic [CNT_W-1:0]  cnt_reg;
    logic              busy_reg;
    logic              last_iter;

    // Accumulator value after the iteration performed on the coming edge.
    assign acc_next  = mplier_reg[0] ? (acc_reg + mcand_reg) : acc_reg;
    assign last_iter = (cnt_reg == CNT_W'(DATA_W - 1));

    assign busy    = busy_reg;
    // done/product are combinational so the parent can register the final
    // product on the very edge that performs the last iteration.
    assign done    = busy_reg && last_iter;
    assign product = acc_next;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mcand_reg  <= '0;
            mplier_reg <= '0;
            acc_reg    <= '0;
            cnt_reg    <= '0;
            busy_reg   <= 1'b0;
        end else if (busy_reg) begin
            acc_reg    <= acc_next;
            mcand_reg  <= {mcand_reg[DATA_W-2:0], 1'b0};
            mplier_reg <= {1'b0, mplier_reg[DATA_W-1:1]};
            cnt_reg    <= cnt_reg + CNT_W'(1);
            if (last_iter) begin
                busy_reg <= 1'b0;
            end
        end else if (start) begin
            mcand_reg  <= a;
            mplier_reg <= b;
            acc_reg    <= '0;
            cnt_reg    <= '0;
            busy_reg   <= 1'b1;
        end
    end

endmodule

// File: rtl/alu_unit.sv
// ---------------------------------------------------------------------------
// alu_unit
//   Arithmetic stage behind the control unit. ADD/SUB/SFTR/SFTL commit in
//   the accepting edge; MUL runs through seq_multiplier and commits DATA_W
//   edges later. NOP and reserved codes leave result/z alone but still pulse
//   done so the control unit never waits forever.
//
// Ports
//   clk      in   system clock
//   rst_n    in   synchronous active-low reset (aborts MUL, no done)
//   start    in   one-cycle strobe; accepted only while busy is low
//   alu_op   in   op code (see alu_unit_pkg)
//   op_a     in   accumulator operand
//   op_b     in   bus operand
//   result   out  registered result for AC write-back
//   z        out  registered zero flag of the last committed result
//   busy     out  high while a MUL is iterating
//   done     out  one-cycle pulse after each committed operation
// ---------------------------------------------------------------------------
module alu_unit
    import alu_unit_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [2:0]        alu_op,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    output logic [DATA_W-1:0] result,
    output logic              z,
    output logic              busy,
    output logic              done
);

    logic              accept;
    logic              mul_start;
    logic              mul_busy;
    logic              mul_done;
    logic [DATA_W-1:0] mul_product;

    logic [DATA_W-1:0] result_reg;
    logic [DATA_W-1:0] result_next;
    logic              z_reg;
    logic              z_next;
    logic              done_reg;
    logic              done_next;
    logic              commit;
    logic [DATA_W-1:0] commit_val;

    // A start during a multiply is dropped completely.
    assign accept    = start && !mul_busy;
    assign mul_start = accept && (alu_op == ALU_MUL);

    seq_multiplier #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .a       (op_a),
        .b       (op_b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    always_comb begin
        commit     = 1'b0;
        commit_val = '0;
        done_next  = 1'b0;
        // mul_done and accept are mutually exclusive: busy is high whenever
        // the multiplier is finishing.
        if (mul_done) begin
            commit     = 1'b1;
            commit_val = mul_product;
            done_next  = 1'b1;
        end else if (accept) begin
            done_next = (alu_op != ALU_MUL);
            case (alu_op)
                ALU_ADD: begin
                    commit     = 1'b1;
                    commit_val = op_a + op_b;
                end
                ALU_SUB: begin
                    commit     = 1'b1;
                    commit_val = op_a - op_b;
                end
                ALU_SFTR: begin
                    commit     = 1'b1;
                    commit_val = {1'b0, op_a[DATA_W-1:1]};
                end
                ALU_SFTL: begin
                    commit     = 1'b1;
                    commit_val = {op_a[DATA_W-2:0], 1'b0};
                end
                default: begin
                    commit     = 1'b0;
                    commit_val = '0;
                end
            endcase
        end
    end

    assign result_next = commit ? commit_val : result_reg;
    assign z_next      = commit ? (commit_val == '0) : z_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result_reg <= '0;
            z_reg      <= 1'b1;
            done_reg   <= 1'b0;
        end else begin
            result_reg <= result_next;
            z_reg      <= z_next;
            done_reg   <= done_next;
        end
    end

    assign result = result_reg;
    assign z      = z_reg;
    assign busy   = mul_busy;
    assign done   = done_reg;

endmodule

// File: doc/alu_unit.md
Name: alu_unit

Overview:
Arithmetic stage directly downstream of the control unit. It consumes the 3-bit alu op code and a start strobe, operates on the accumulator value and the bus operand, and returns a registered result for AC write-back. It also returns the zero flag Z, which the control unit uses for its JUMPZ/JMNZ branches. ADD, SUB and the shifts complete in one cycle. MUL is an iterative shift-add with a busy/done handshake, so the control unit must hold in a wait state until done.

Parameters:
DATA_W, 16, datapath width of operands and result.
CNT_W, 5, width of the multiply iteration counter; must satisfy 2^CNT_W > DATA_W.

Ports:
clk  in  1  system clock; all state updates on the rising edge.
rst_n  in  1  synchronous active-low reset, sampled on the rising edge of clk.
start  in  1  one-cycle strobe from the control unit; the op and operands are sampled on this edge.
alu_op  in  3  op code: 0 NOP, 1 ADD, 2 MUL, 3 SUB, 4 SFTR, 5 SFTL, 6/7 reserved.
op_a  in  DATA_W  accumulator operand.
op_b  in  DATA_W  bus operand.
result  out  DATA_W  registered result, fed to the AC write path.
z  out  1  registered flag, 1 when the last committed result equals 0.
busy  out  1  high while a MUL is iterating.
done  out  1  one-cycle pulse when the result and z are committed.

Behaviour:
- Reset (rst_n=0 at an edge): result=0, z=1, busy=0, done=0, multiplier state cleared. Reset during a MUL aborts it with no done pulse.
- Accept rule: start is accepted only at an edge where busy=0. A start while busy=1 is ignored entirely; operands are not sampled and no extra done is produced.
- Single-cycle ops, with start accepted at edge E0:
  - At E0, result and z are written; done=1 for the cycle following E0. busy stays 0.
  - ADD: (op_a+op_b) mod 2^DATA_W.
  - SUB: (op_a-op_b) mod 2^DATA_W.
  - SFTR: op_a logical shift right by 1, MSB filled with 0.
  - SFTL: op_a shift left by 1, LSB filled with 0.
  - Carries and overflows are discarded; there is no carry flag.
- NOP and reserved codes 6/7: result and z are unchanged; done still pulses after E0, so the control unit never hangs.
- MUL, with start accepted at E0:
  - At E0: load mcand=op_a, mplier=op_b, acc=0, cnt=0; busy=1 from the cycle after E0.
  - At each edge E1..E_DATA_W: if mplier[0]=1 then acc += mcand (mod 2^DATA_W); then mcand <<= 1, mplier >>= 1, cnt++.
  - At edge E_DATA_W: result=final acc (low DATA_W bits of the product), z=(acc==0), done=1 for one cycle, busy=0.
  - Latency is a fixed DATA_W edges regardless of operand values; there is no early exit.
  - result and z hold their previous values throughout the iteration.
- Back-to-back: a start in the same cycle that done is high is accepted, since busy=0 there.
- Operands may change after E0; only the values sampled at E0 are used.
- z always tracks the most recent committed result and holds between operations.

Decomposition:
- Shared package: the ALU op-code constants (NOP/ADD/MUL/SUB/SFTR/SFTL). The control unit imports the same package so the codes are defined once.
- One natural sub-module: seq_multiplier.
  - Ports: clk, rst_n, start, a, b, busy, done, product.
  - Contains the counter and shift-add registers.
  - alu_unit keeps the op decode, the single-cycle ops, the result/z registers and the done merge.

Test Plan:
- Reset, then ADD op_a=5, op_b=7 -> one cycle later result=12, z=0, done pulses once, busy stays 0.
- SUB 0x0007-0x0007 -> result=0x0000, z=1. ADD 0xFFFF+0x0001 -> result=0x0000, z=1 (wrap).
- SFTR op_a=0x8001 -> 0x4000. SFTL op_a=0x8001 -> 0x0002, z=0.
- MUL 3*4 -> busy high for 16 cycles, result=12 and done on the 16th edge. MUL 0x0100*0x0100 -> result=0, z=1.
- MUL 3*4, then start ADD 1+1 at cycle 5 of busy -> ignored, final result=12, a single done. Then ADD 1+1 issued in the done cycle -> result=2 on the next cycle.
- MUL started, rst_n=0 at cycle 8 -> next cycle result=0, z=1, busy=0, and no done pulse ever appears. Then NOP -> done pulses, result stays 0.
